// File: rtl/image_blur_feeder.sv
// image_blur_feeder
//   Frame buffer front-end for an image_blur core. The host loads an input
//   frame (N = WIDTH*HEIGHT*3 bytes) through the write port while idle. A go
//   request latches the kernel, raises start and streams the frame one byte
//   per clock. The block then waits for blur_done, skips one cycle, and
//   captures N result bytes into an output frame RAM. A one-cycle FINISH
//   state pulses frame_done. If blur_done never arrives within TIMEOUT
//   cycles, the run is abandoned and timeout_err is raised.
//
// Ports
//   clk, reset            : clock, synchronous active-high reset
//   wr_en/wr_addr/wr_data : host write port into the input frame RAM (idle only)
//   go, kernel_sel        : run request and kernel choice (latched on go)
//   start, kernel_type    : control towards image_blur
//   image_in, in_valid    : byte stream towards image_blur
//   blur_done, image_out  : completion flag and result bytes from image_blur
//   rd_addr, rd_data      : host read port of the output frame RAM (1-cycle latency)
//   busy, frame_done, timeout_err : status
module image_blur_feeder #(
  parameter int WIDTH   = 350,
  parameter int HEIGHT  = 350,
  parameter int ADDR_W  = 19,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              go,
  input  logic [1:0]        kernel_sel,
  output logic              start,
  output logic [1:0]        kernel_type,
  output logic [7:0]        image_in,
  output logic              in_valid,
  input  logic              blur_done,
  input  logic [7:0]        image_out,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);

  localparam int N     = WIDTH * HEIGHT * 3;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [ADDR_W:0]   N_EXT    = (ADDR_W + 1)'(N);
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_WAIT_DONE,
    S_GAP,
    S_CAPTURE,
    S_FINISH
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic              r_last;
  logic [TMR_W-1:0]  r_tmr;
  logic              r_start;
  logic [1:0]        r_ktype;
  logic [7:0]        r_img;
  logic              r_vld;
  logic              r_busy;
  logic              r_fdone;
  logic              r_terr;
  logic [7:0]        r_rd_data;

  logic [7:0] r_in_mem  [0:N-1];
  logic [7:0] r_out_mem [0:N-1];

  logic             w_wr_ok;
  logic             w_rd_ok;
  logic             w_cap_we;
  logic [IDX_W-1:0] w_idx;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;

  // Host writes are only honoured while idle and inside the frame.
  assign w_wr_ok  = wr_en & ~r_busy & ({1'b0, wr_addr} < N_EXT);
  assign w_rd_ok  = ({1'b0, rd_addr} < N_EXT);
  // Gating with reset guarantees a mid-capture reset stops RAM writes on the same edge.
  assign w_cap_we = (r_state == S_CAPTURE) & ~reset;
  assign w_idx    = r_cnt[IDX_W-1:0];
  assign w_rd_idx = rd_addr[IDX_W-1:0];
  assign w_wr_idx = wr_addr[IDX_W-1:0];

  // Input frame RAM: host write port, contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_in_mem[w_wr_idx] <= wr_data;
    end
  end

  // Output frame RAM: capture write port plus registered host read.
  // A read of the address being written returns the previous contents.
  always_ff @(posedge clk) begin
    if (w_cap_we) begin
      r_out_mem[w_idx] <= image_out;
    end
    r_rd_data <= w_rd_ok ? r_out_mem[w_rd_idx] : 8'h00;
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_tmr   <= '0;
      r_start <= 1'b0;
      r_ktype <= 2'd0;
      r_img   <= 8'h00;
      r_vld   <= 1'b0;
      r_busy  <= 1'b0;
      r_fdone <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_fdone <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (go) begin
            r_ktype <= kernel_sel;
            r_cnt   <= '0;
            r_last  <= 1'b0;
            r_start <= 1'b1;
            r_busy  <= 1'b1;
            r_terr  <= 1'b0;
            r_state <= S_STREAM;
          end
        end

        S_STREAM: begin
          // r_last marks that byte N-1 is already on image_in; it is held
          // for one more cycle before in_valid drops, and the counter never
          // advances past N-1.
          if (r_last) begin
            r_vld   <= 1'b0;
            r_tmr   <= '0;
            r_state <= S_WAIT_DONE;
          end else begin
            r_img <= r_in_mem[w_idx];
            r_vld <= 1'b1;
            if (r_cnt == LAST_IDX) begin
              r_last <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end

        S_WAIT_DONE: begin
          if (blur_done) begin
            r_state <= S_GAP;
          end else if (r_tmr == TMR_LAST) begin
            r_terr  <= 1'b1;
            r_start <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_tmr <= r_tmr + 1'b1;
          end
        end

        // The first image_blur output cycle after done is not data.
        S_GAP: begin
          r_cnt   <= '0;
          r_state <= S_CAPTURE;
        end

        S_CAPTURE: begin
          if (r_cnt == LAST_IDX) begin
            r_start <= 1'b0;
            r_fdone <= 1'b1;
            r_state <= S_FINISH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_FINISH: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign start       = r_start;
  assign kernel_type = r_ktype;
  assign image_in    = r_img;
  assign in_valid    = r_vld;
  assign busy        = r_busy;
  assign frame_done  = r_fdone;
  assign timeout_err = r_terr;
  assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_image_blur_feeder.sv
module tb_image_blur_feeder;

  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = W * H * 3;
  localparam int AW = 5;
  localparam int TO = 50;

  logic          clk = 1'b0;
  logic          reset;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          go;
  logic [1:0]    kernel_sel;
  logic          start;
  logic [1:0]    kernel_type;
  logic [7:0]    image_in;
  logic          in_valid;
  logic          blur_done;
  logic [7:0]    image_out;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;
  logic          frame_done;
  logic          timeout_err;

  always #5 clk = ~clk;

  image_blur_feeder #(
    .WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .go(go), .kernel_sel(kernel_sel),
    .start(start), .kernel_type(kernel_type),
    .image_in(image_in), .in_valid(in_valid),
    .blur_done(blur_done), .image_out(image_out),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  int errors = 0;
  int checks = 0;
  int vcount = 0;
  int fdcount = 0;

  logic [7:0] exp_q[$];
  logic [7:0] in_model  [N];
  logic [7:0] out_model [N];
  bit         out_known = 1'b0;

  // Modes: 0 normal, 1 go/wr during stream, 2 blur_done during stream,
  //        3 timeout, 4 reset at byte 10 then replay
  typedef struct {
    logic [1:0] ksel;
    bit         reload;
    logic [7:0] base;
    logic [7:0] obase;
    int         mode;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Stream scoreboard and frame_done pulse counter, sampled mid-cycle.
  always @(negedge clk) begin
    if (in_valid) begin
      vcount++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL stream_extra: got=%0h want=none", image_in);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        chk("stream_byte", 32'(image_in), 32'(e));
      end
    end
    if (frame_done) fdcount++;
  end

  task automatic load(input logic [7:0] base);
    for (int i = 0; i < N; i++) begin
      wr_en   = 1'b1;
      wr_addr = AW'(i);
      wr_data = 8'(base + 8'(i));
      in_model[i] = 8'(base + 8'(i));
      tick();
    end
    // out-of-frame write must be dropped
    wr_addr = AW'(N + 3);
    wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_frame(input logic [1:0] ksel);
    vcount  = 0;
    fdcount = 0;
    for (int i = 0; i < N; i++) exp_q.push_back(in_model[i]);
    kernel_sel = ksel;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("e0_start", 32'(start), 32'd1);
    chk("e0_kernel_type", 32'(kernel_type), 32'(ksel));
    chk("e0_busy", 32'(busy), 32'd1);
    chk("e0_timeout_err", 32'(timeout_err), 32'd0);
  endtask

  task automatic stream(input int mode, input logic [1:0] ksel, output bit aborted);
    aborted = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (mode == 1 && k >= 2 && k < 5) begin
        go = 1'b1; kernel_sel = ~ksel;
        wr_en = 1'b1; wr_addr = AW'(3); wr_data = 8'hFF;
      end else begin
        go = 1'b0; wr_en = 1'b0;
      end
      blur_done = (mode == 2 && k == 6);
      tick();
      if (mode == 4 && k == 10) begin
        reset = 1'b1;
        tick();
        chk("rst_start", 32'(start), 32'd0);
        chk("rst_in_valid", 32'(in_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_image_in", 32'(image_in), 32'd0);
        chk("rst_kernel_type", 32'(kernel_type), 32'd0);
        chk("rst_bytes_seen", 32'(vcount), 32'd11);
        exp_q.delete();
        reset = 1'b0;
        aborted = 1'b1;
        return;
      end
    end
    go = 1'b0; wr_en = 1'b0; blur_done = 1'b0;
    tick();
    chk("end_in_valid", 32'(in_valid), 32'd0);
    chk("end_image_in_hold", 32'(image_in), 32'(in_model[N-1]));
    chk("end_start", 32'(start), 32'd1);
    chk("end_busy", 32'(busy), 32'd1);
    chk("end_kernel_type", 32'(kernel_type), 32'(ksel));
    chk("valid_cycles", 32'(vcount), 32'(N));
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic capture(input logic [7:0] obase);
    blur_done = 1'b1;
    tick();              // edge D
    blur_done = 1'b0;
    image_out = 8'hEE;
    tick();              // edge D+1, not captured
    for (int i = 0; i < N; i++) begin
      image_out = 8'(obase + 8'(i));
      rd_addr   = AW'(i);
      tick();            // edge D+2+i
      if (out_known) chk("rd_old_during_capture", 32'(rd_data), 32'(out_model[i]));
      if (i < N - 1) chk("no_early_done", 32'(frame_done), 32'd0);
    end
    for (int i = 0; i < N; i++) out_model[i] = 8'(obase + 8'(i));
    out_known = 1'b1;
    chk("finish_frame_done", 32'(frame_done), 32'd1);
    chk("finish_start", 32'(start), 32'd0);
    chk("finish_busy", 32'(busy), 32'd1);
    tick();              // edge D+N+2
    chk("idle_frame_done", 32'(frame_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("frame_done_pulses", 32'(fdcount), 32'd1);
    rd_addr = AW'(5);
    tick();
    chk("rd_addr5", 32'(rd_data), 32'(out_model[5]));
    for (int i = 0; i < N; i++) begin
      rd_addr = AW'(i);
      tick();
      chk("rd_back", 32'(rd_data), 32'(out_model[i]));
    end
  endtask

  task automatic timeout_seq();
    repeat (TO - 1) tick();
    chk("pre_to_err", 32'(timeout_err), 32'd0);
    chk("pre_to_busy", 32'(busy), 32'd1);
    tick();
    chk("to_err", 32'(timeout_err), 32'd1);
    chk("to_start", 32'(start), 32'd0);
    chk("to_busy", 32'(busy), 32'd0);
    repeat (5) tick();
    chk("to_err_held", 32'(timeout_err), 32'd1);
    chk("to_no_frame_done", 32'(fdcount), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  initial begin
    bit ab;
    tbl[0] = '{ksel: 2'd1, reload: 1'b1, base: 8'h00, obase: 8'hA0, mode: 0};
    tbl[1] = '{ksel: 2'd2, reload: 1'b0, base: 8'h00, obase: 8'h30, mode: 1};
    tbl[2] = '{ksel: 2'd3, reload: 1'b0, base: 8'h00, obase: 8'h60, mode: 2};
    tbl[3] = '{ksel: 2'd0, reload: 1'b0, base: 8'h00, obase: 8'h00, mode: 3};
    tbl[4] = '{ksel: 2'd1, reload: 1'b0, base: 8'h00, obase: 8'hC0, mode: 4};
    tbl[5] = '{ksel: 2'd2, reload: 1'b1, base: 8'h40, obase: 8'h10, mode: 0};

    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = 8'h00;
    go = 1'b0; kernel_sel = 2'd0; blur_done = 1'b0; image_out = 8'h00;
    rd_addr = '0;
    repeat (3) tick();
    chk("reset_start", 32'(start), 32'd0);
    chk("reset_in_valid", 32'(in_valid), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_frame_done", 32'(frame_done), 32'd0);
    chk("reset_timeout_err", 32'(timeout_err), 32'd0);
    chk("reset_image_in", 32'(image_in), 32'd0);
    chk("reset_kernel_type", 32'(kernel_type), 32'd0);
    reset = 1'b0;
    tick();

    // blur_done while idle must do nothing
    fdcount = 0;
    blur_done = 1'b1;
    tick();
    blur_done = 1'b0;
    repeat (3) tick();
    chk("idle_done_busy", 32'(busy), 32'd0);
    chk("idle_done_fd", 32'(fdcount), 32'd0);

    for (int t = 0; t < 6; t++) begin
      if (tbl[t].reload) load(tbl[t].base);
      start_frame(tbl[t].ksel);
      stream(tbl[t].mode, tbl[t].ksel, ab);
      if (ab) begin
        chk("abort_no_frame_done", 32'(fdcount), 32'd0);
        start_frame(tbl[t].ksel);
        stream(0, tbl[t].ksel, ab);
      end
      if (tbl[t].mode == 3) timeout_seq();
      else capture(tbl[t].obase);
      repeat (2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
